// File: rtl/branch_pc_unit.sv
//==============================================================================
// Module   : branch_pc_unit
// Brief    : Fetch PC sequencer with branch/jump redirect, IF/ID flush pulse
//            and saturating branch statistics.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             branch_valid_i,
  input  logic             sig_branch_i,
  input  logic [31:0]      ex_pc_plus4_i,
  input  logic [15:0]      immediate_i,
  input  logic             jump_i,
  input  logic [25:0]      jump_target_i,
  input  logic [31:0]      id_pc_plus4_i,
  output logic [31:0]      pc_o,
  output logic             fetch_valid_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t             state_q;
  logic [31:0]        pc_q;
  logic               fetch_valid_q;
  logic               flush_q;
  logic [CNT_W-1:0]   branch_cnt_q;
  logic [CNT_W-1:0]   taken_cnt_q;
  logic [CNT_W-1:0]   branch_cnt_d;
  logic [CNT_W-1:0]   taken_cnt_d;

  logic               accept;
  logic               br_taken;
  logic               do_jump;
  logic [31:0]        branch_tgt;
  logic [31:0]        jump_tgt;

  // Word offset is sign-extended and scaled to bytes; sums wrap modulo 2^32.
  assign branch_tgt = ex_pc_plus4_i + {{14{immediate_i[15]}}, immediate_i, 2'b00};
  assign jump_tgt   = {id_pc_plus4_i[31:28], jump_target_i, 2'b00};

  // Redirect decode and saturating counter next-state. The cycle right after
  // a flush holds only killed instructions, so their requests are dropped;
  // this also keeps flush from ever being asserted on back-to-back cycles.
  always_comb begin
    accept       = (state_q == RUN) && !flush_q;
    br_taken     = accept && branch_valid_i && sig_branch_i;
    do_jump      = accept && jump_i && !br_taken;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (accept && branch_valid_i && !(&branch_cnt_q)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (br_taken && !(&taken_cnt_q)) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
  end

  // Control FSM with all outputs registered; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          // PC already holds RESET_PC; it becomes the first valid fetch.
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
          flush_q       <= 1'b0;
        end
        RUN: begin
          branch_cnt_q <= branch_cnt_d;
          taken_cnt_q  <= taken_cnt_d;
          if (br_taken) begin
            pc_q          <= branch_tgt;
            fetch_valid_q <= 1'b1;
            flush_q       <= 1'b1;
            state_q       <= REDIR;
          end else if (do_jump) begin
            pc_q          <= jump_tgt;
            fetch_valid_q <= 1'b1;
            flush_q       <= 1'b1;
          end else begin
            flush_q <= 1'b0;
            if (!stall_i) begin
              pc_q          <= pc_q + 32'd4;
              fetch_valid_q <= 1'b1;
            end
          end
        end
        REDIR: begin
          // Branch/jump inputs here belong to flushed instructions.
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
          flush_q       <= 1'b0;
          if (!stall_i) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        default: begin
          state_q       <= BOOT;
          fetch_valid_q <= 1'b0;
          flush_q       <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = fetch_valid_q;
  assign flush_o       = flush_q;
  assign branch_cnt_o  = branch_cnt_q;
  assign taken_cnt_o   = taken_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
//==============================================================================
// Module   : tb_branch_pc_unit
// Brief    : Directed scoreboard bench for branch_pc_unit (16-bit and 4-bit
//            counter instances driven in parallel).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_branch_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        bv;
  logic        sb;
  logic [31:0] ex4;
  logic [15:0] imm;
  logic        jmp;
  logic [25:0] jt;
  logic [31:0] id4;

  logic [31:0] pc;
  logic        fv;
  logic        fl;
  logic [15:0] bcnt;
  logic [15:0] tcnt;

  logic [31:0] s_pc;
  logic        s_fv;
  logic        s_fl;
  logic [3:0]  s_bcnt;
  logic [3:0]  s_tcnt;

  branch_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_valid_i(bv), .sig_branch_i(sb),
    .ex_pc_plus4_i(ex4), .immediate_i(imm), .jump_i(jmp), .jump_target_i(jt),
    .id_pc_plus4_i(id4), .pc_o(pc), .fetch_valid_o(fv), .flush_o(fl),
    .branch_cnt_o(bcnt), .taken_cnt_o(tcnt)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  branch_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_valid_i(bv), .sig_branch_i(sb),
    .ex_pc_plus4_i(ex4), .immediate_i(imm), .jump_i(jmp), .jump_target_i(jt),
    .id_pc_plus4_i(id4), .pc_o(s_pc), .fetch_valid_o(s_fv), .flush_o(s_fl),
    .branch_cnt_o(s_bcnt), .taken_cnt_o(s_tcnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        fv;
    logic        fl;
    logic [15:0] bc;
    logic [15:0] tc;
  } exp_s;

  exp_s        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_b;
  logic [15:0] exp_t;

  function automatic logic [15:0] sat4(input logic [15:0] v);
    return (v > 16'd15) ? 16'd15 : v;
  endfunction

  task automatic chk(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic clear_in();
    stall = 1'b0; bv = 1'b0; sb = 1'b0; ex4 = '0; imm = '0;
    jmp = 1'b0; jt = '0; id4 = '0;
  endtask

  // Push the expectation for the coming edge, clock, then pop and compare.
  task automatic step(input string tag, input logic [31:0] epc, input logic efv,
                      input logic efl);
    exp_s e;
    e.tag = tag; e.pc = epc; e.fv = efv; e.fl = efl; e.bc = exp_b; e.tc = exp_t;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk(e.tag, "pc",         pc,             e.pc);
    chk(e.tag, "fetch_valid", {31'd0, fv},   {31'd0, e.fv});
    chk(e.tag, "flush",      {31'd0, fl},    {31'd0, e.fl});
    chk(e.tag, "branch_cnt", {16'd0, bcnt},  {16'd0, e.bc});
    chk(e.tag, "taken_cnt",  {16'd0, tcnt},  {16'd0, e.tc});
    chk(e.tag, "sat_branch_cnt", {28'd0, s_bcnt}, {16'd0, sat4(e.bc)});
    chk(e.tag, "sat_taken_cnt",  {28'd0, s_tcnt}, {16'd0, sat4(e.tc)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_b = '0; exp_t = '0;
    rst = 1'b1; clear_in();
    step("reset", 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step("boot", 32'h0, 1'b1, 1'b0);
    step("seq1", 32'h4, 1'b1, 1'b0);
    step("seq2", 32'h8, 1'b1, 1'b0);

    // BNE taken, offset -2 words from 0x10
    bv = 1'b1; sb = 1'b1; ex4 = 32'h10; imm = 16'hFFFE;
    exp_b = 16'd1; exp_t = 16'd1;
    step("bne_taken", 32'h8, 1'b1, 1'b1);
    clear_in();
    step("redir", 32'hC, 1'b1, 1'b0);
    step("seq_10", 32'h10, 1'b1, 1'b0);
    step("seq_14", 32'h14, 1'b1, 1'b0);
    step("seq_18", 32'h18, 1'b1, 1'b0);
    step("seq_1c", 32'h1C, 1'b1, 1'b0);
    step("seq_20", 32'h20, 1'b1, 1'b0);

    // BNE not taken at 0x20
    bv = 1'b1; sb = 1'b0; exp_b = 16'd2;
    step("bne_nt", 32'h24, 1'b1, 1'b0);
    clear_in();
    // sig_branch alone is ignored
    sb = 1'b1;
    step("sig_only", 32'h28, 1'b1, 1'b0);
    clear_in();
    stall = 1'b1;
    step("stall", 32'h28, 1'b1, 1'b0);

    // Taken branch beats jump and stall
    stall = 1'b1; jmp = 1'b1; jt = 26'h0000123; id4 = 32'h8000_0000;
    bv = 1'b1; sb = 1'b1; ex4 = 32'h100; imm = 16'h0010;
    exp_b = 16'd3; exp_t = 16'd2;
    step("br_over_jump", 32'h140, 1'b1, 1'b1);
    // REDIR ignores branch/jump inputs
    stall = 1'b0; ex4 = 32'h0; imm = 16'h0;
    step("redir_ignore", 32'h144, 1'b1, 1'b0);
    clear_in();
    step("seq_148", 32'h148, 1'b1, 1'b0);

    // Stall during REDIR holds the redirected PC
    bv = 1'b1; sb = 1'b1; ex4 = 32'h200; imm = 16'hFFFF;
    exp_b = 16'd4; exp_t = 16'd3;
    step("br_1fc", 32'h1FC, 1'b1, 1'b1);
    clear_in(); stall = 1'b1;
    step("redir_stall", 32'h1FC, 1'b1, 1'b0);
    clear_in();
    step("seq_200", 32'h200, 1'b1, 1'b0);

    // Jump
    jmp = 1'b1; id4 = 32'h4000_0010; jt = 26'h000_0100;
    step("jump", 32'h4000_0400, 1'b1, 1'b1);
    clear_in();
    step("jump_next", 32'h4000_0404, 1'b1, 1'b0);

    // Jump to 0xFFFF_FFFC then sequential wrap to 0
    jmp = 1'b1; id4 = 32'hF000_0000; jt = 26'h3FF_FFFF;
    step("jump_top", 32'hFFFF_FFFC, 1'b1, 1'b1);
    clear_in();
    step("wrap", 32'h0, 1'b1, 1'b0);

    // Negative offset wraps below zero
    bv = 1'b1; sb = 1'b1; ex4 = 32'h4; imm = 16'hFFF0;
    exp_b = 16'd5; exp_t = 16'd4;
    step("neg_wrap", 32'hFFFF_FFC4, 1'b1, 1'b1);
    clear_in();
    step("neg_redir", 32'hFFFF_FFC8, 1'b1, 1'b0);

    // Taken-branch burst: the 4-bit instance must pin at 0xF
    for (int i = 0; i < 20; i++) begin
      bv = 1'b1; sb = 1'b1; ex4 = 32'h1000; imm = 16'h0;
      exp_b = exp_b + 16'd1; exp_t = exp_t + 16'd1;
      step("sat_taken", 32'h1000, 1'b1, 1'b1);
      clear_in();
      step("sat_redir", 32'h1004, 1'b1, 1'b0);
    end

    // Reset asserted while in REDIR with a taken branch presented
    bv = 1'b1; sb = 1'b1; ex4 = 32'h300; imm = 16'h0;
    exp_b = exp_b + 16'd1; exp_t = exp_t + 16'd1;
    step("pre_rst_br", 32'h300, 1'b1, 1'b1);
    rst = 1'b1;
    exp_b = 16'd0; exp_t = 16'd0;
    step("rst_in_redir", 32'h0, 1'b0, 1'b0);
    rst = 1'b0; clear_in();
    step("reboot", 32'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: CNT_W, 16, width of branch statistic counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 stall  input  1  hold PC (load-use/memory stall); no fetch advance.
REQ-006 branch_valid  input  1  conditional branch (BEQ/BNE) resolving in EX this cycle.
REQ-007 sig_branch  input  1  ALU branch decision for the EX instruction; 1 = taken.
REQ-008 ex_pc_plus4  input  32  PC+4 of the EX-stage branch.
REQ-009 immediate  input  16  EX-stage branch offset, in words, two's complement.
REQ-010 jump  input  1  J-type jump decoded in ID this cycle.
REQ-011 jump_target  input  26  J-type target field.
REQ-012 id_pc_plus4  input  32  PC+4 of the ID-stage jump.
REQ-013 pc  output  32  current fetch address.
REQ-014 fetch_valid  output  1  pc is a valid fetch this cycle.
REQ-015 flush  output  1  kill IF/ID (and ID/EX on taken branch) pipeline registers.
REQ-016 branch_cnt  output  CNT_W  resolved branches seen.
REQ-017 taken_cnt  output  CNT_W  taken branches seen.

Function
REQ-018 All outputs SHALL be registered; no combinational input-to-output path.
REQ-019 FSM states SHALL be: BOOT, RUN, REDIR.
REQ-020 BOOT: entered on reset, lasts exactly 1 cycle, fetch_valid=0, then RUN unconditionally.
REQ-021 RUN priority per cycle SHALL be: taken branch > jump > stall > sequential.
REQ-022 Taken branch (branch_valid & sig_branch): pc <= ex_pc_plus4 + (sign_extend(immediate) << 2), flush<=1, next state REDIR, regardless of stall.
REQ-023 Jump (jump & no taken branch): pc <= {id_pc_plus4[31:28], jump_target, 2'b00}, flush<=1, state stays RUN.
REQ-024 Stall (no branch taken, no jump): pc, fetch_valid held; flush<=0.
REQ-025 Sequential: pc <= pc + 4, fetch_valid<=1, flush<=0.
REQ-026 REDIR: lasts exactly 1 cycle, fetch_valid=1 at redirected pc, flush<=0, then RUN; pc advances by 4 unless stall.
REQ-027 Branch/jump inputs in REDIR SHALL be ignored (they belong to flushed instructions); counters not updated.
REQ-028 Not-taken branch (branch_valid & !sig_branch): no PC effect beyond REQ-024/025.
REQ-029 flush SHALL be a 1-cycle pulse, never asserted two consecutive cycles.
REQ-030 sig_branch without branch_valid SHALL be ignored.
REQ-031 Address arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000; negative offsets wrap likewise.
REQ-032 branch_cnt SHALL increment on each branch_valid in RUN; taken_cnt on each taken branch in RUN; both saturate at all-ones.

Reset
REQ-033 On rst=1 at a clock edge: pc=RESET_PC, fetch_valid=0, flush=0, branch_cnt=0, taken_cnt=0, state BOOT.
REQ-034 rst SHALL override every other input in the same cycle, including a taken branch mid-redirect.
REQ-035 First valid fetch SHALL be pc=RESET_PC on the second cycle after rst deasserts.

Verification
REQ-036 Reset then run 3 cycles, no branches -> pc 0x0, 0x4, 0x8 with fetch_valid=1, flush=0.
REQ-037 BNE taken: branch_valid=1, sig_branch=1, ex_pc_plus4=0x10, immediate=0xFFFE -> next pc=0x08, flush=1 one cycle, taken_cnt=1, branch_cnt=1.
REQ-038 BNE not taken: branch_valid=1, sig_branch=0, pc=0x20 -> pc=0x24, flush=0, branch_cnt+1, taken_cnt unchanged.
REQ-039 Taken branch with stall=1 and jump=1 same cycle -> branch target loaded, jump ignored; following cycle (REDIR) branch_valid=1,sig_branch=1 ignored.
REQ-040 Jump: jump=1, id_pc_plus4=0x4000_0010, jump_target=26'h000_0100 -> pc=0x4000_0400, flush=1.
REQ-041 Wrap/saturation: pc=0xFFFF_FFFC sequential -> 0x0; force 0xFFFF taken branches -> taken_cnt holds 0xFFFF; rst asserted in REDIR -> all outputs per REQ-033 next cycle.
